// File: rtl/approx_stats_pkg.sv
// Shared state encoding, default widths and saturating adder for the
// approximate-adder error monitor.
package approx_stats_pkg;

  localparam int DEF_W     = 32;
  localparam int DEF_SAE_W = 64;
  localparam int DEF_SSE_W = 96;
  localparam int DEF_CNT_W = 32;
  // Widest accumulator sat_add handles; also bounds the square (2W+2) so W <= 63.
  localparam int ACC_MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [ACC_MAX_W-1:0] acc_t;
  typedef logic [ACC_MAX_W:0]   sat_t;

  // Returns {clamped, value}; value never exceeds 2^width-1.
  function automatic sat_t sat_add(input acc_t a, input acc_t b, input int unsigned width);
    sat_t sum;
    sat_t lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (sat_t'(1) << width) - sat_t'(1);
    if (sum > lim) begin
      sat_add = {1'b1, lim[ACC_MAX_W-1:0]};
    end else begin
      sat_add = {1'b0, sum[ACC_MAX_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/err_sq_stage.sv
// Error datapath: registered |exact - approx| and mismatch flag, plus the
// square of that registered magnitude for the accumulators downstream.
module err_sq_stage #(
  parameter int W = 32
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           i_valid,
  input  logic [W-1:0]   i_approx,
  input  logic [W-1:0]   i_exact,
  output logic           o_valid,
  output logic [W:0]     o_ae,
  output logic           o_ne,
  output logic [2*W+1:0] o_sq
);

  logic [W:0] w_diff;
  logic [W:0] w_ae;
  logic       r_valid;
  logic [W:0] r_ae;
  logic       r_ne;

  // W+1 bits hold every difference of two W-bit signed values, so the
  // magnitude never wraps (worst case 2^W-1).
  assign w_diff = {i_exact[W-1], i_exact} - {i_approx[W-1], i_approx};
  assign w_ae   = w_diff[W] ? -w_diff : w_diff;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_valid <= 1'b0;
      r_ae    <= '0;
      r_ne    <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_ae <= w_ae;
        r_ne <= (i_approx != i_exact);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_ae    = r_ae;
  assign o_ne    = r_ne;
  assign o_sq    = {{(W+1){1'b0}}, r_ae} * {{(W+1){1'b0}}, r_ae};

endmodule

// File: rtl/approx_err_monitor.sv
// Streaming error-statistics collector for approximate-adder characterisation.
//   state | meaning
//   IDLE  | waiting for start; last statistics still readable
//   RUN   | accepting pairs until target reached
//   DRAIN | last pair still in the pipeline
//   DONE  | statistics record presented, waiting for out_ready
module approx_err_monitor
  import approx_stats_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int SAE_W = DEF_SAE_W,
  parameter int SSE_W = DEF_SSE_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     approx,
  input  logic [W-1:0]     exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SAE_W-1:0] sae,
  output logic [SSE_W-1:0] sse,
  output logic [W:0]       max_ae,
  output logic             ovf
);

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_accepted;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [SAE_W-1:0] r_sae;
  logic [SSE_W-1:0] r_sse;
  logic [W:0]       r_max_ae;
  logic             r_ovf;

  logic             w_start_acc;
  logic             w_accept;
  logic             w_last;
  logic             w_s1_valid;
  logic [W:0]       w_s1_ae;
  logic             w_s1_ne;
  logic [2*W+1:0]   w_sq;
  sat_t             w_cnt_res;
  sat_t             w_err_res;
  sat_t             w_sae_res;
  sat_t             w_sse_res;
  logic             w_clamp;
  logic             w_unused_hi;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_accept    = in_valid && in_ready;
  assign w_last      = w_accept && (r_accepted == (r_target - CNT_W'(1)));

  err_sq_stage #(.W(W)) u_err_sq (
    .Clk      (Clk),
    .Rst      (Rst),
    .i_valid  (w_accept),
    .i_approx (approx),
    .i_exact  (exact),
    .o_valid  (w_s1_valid),
    .o_ae     (w_s1_ae),
    .o_ne     (w_s1_ne),
    .o_sq     (w_sq)
  );

  assign w_cnt_res = sat_add(acc_t'(r_sample_cnt), acc_t'(1), CNT_W);
  assign w_err_res = sat_add(acc_t'(r_err_cnt), acc_t'(w_s1_ne), CNT_W);
  assign w_sae_res = sat_add(acc_t'(r_sae), acc_t'(w_s1_ae), SAE_W);
  assign w_sse_res = sat_add(acc_t'(r_sse), acc_t'(w_sq), SSE_W);
  assign w_clamp   = w_cnt_res[ACC_MAX_W] | w_err_res[ACC_MAX_W]
                   | w_sae_res[ACC_MAX_W] | w_sse_res[ACC_MAX_W];
  // Bits above each accumulator width are always zero after clamping.
  assign w_unused_hi = ^{w_cnt_res[ACC_MAX_W-1:CNT_W], w_err_res[ACC_MAX_W-1:CNT_W],
                         w_sae_res[ACC_MAX_W-1:SAE_W], w_sse_res[ACC_MAX_W-1:SSE_W]};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (num_samples == '0) ? DONE : RUN;
      RUN:     if (w_last) w_next = DRAIN;
      DRAIN:   if (!w_s1_valid) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == RUN);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_target     <= '0;
      r_accepted   <= '0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_sae        <= '0;
      r_sse        <= '0;
      r_max_ae     <= '0;
      r_ovf        <= 1'b0;
    end else if (w_start_acc) begin
      r_target     <= num_samples;
      r_accepted   <= '0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_sae        <= '0;
      r_sse        <= '0;
      r_max_ae     <= '0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_accepted <= r_accepted + CNT_W'(1);
      end
      if (w_s1_valid) begin
        r_sample_cnt <= w_cnt_res[CNT_W-1:0];
        r_err_cnt    <= w_err_res[CNT_W-1:0];
        r_sae        <= w_sae_res[SAE_W-1:0];
        r_sse        <= w_sse_res[SSE_W-1:0];
        if (w_s1_ae > r_max_ae) r_max_ae <= w_s1_ae;
        if (w_clamp) r_ovf <= 1'b1;
      end
    end
  end

  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign sae        = r_sae;
  assign sse        = r_sse;
  assign max_ae     = r_max_ae;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Self-checking bench for approx_err_monitor: a default-width instance and an
// 8-bit-SAE instance share one stimulus stream.
module tb_approx_err_monitor;

  localparam int W      = 32;
  localparam int CNT_W  = 32;
  localparam int SAE_W  = 64;
  localparam int SSE_W  = 96;
  localparam int SAE8_W = 8;

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     approx = '0;
  logic [W-1:0]     exact = '0;
  logic             out_ready = 1'b0;

  logic             in_ready, out_valid, busy, ovf;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [SAE_W-1:0] sae;
  logic [SSE_W-1:0] sse;
  logic [W:0]       max_ae;

  logic              in_ready8, out_valid8, busy8, ovf8;
  logic [CNT_W-1:0]  sample_cnt8, err_cnt8;
  logic [SAE8_W-1:0] sae8;
  logic [SSE_W-1:0]  sse8;
  logic [W:0]        max_ae8;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [W-1:0] q_a[$];
  logic signed [W-1:0] q_e[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   e;
    logic [W:0]     ae;
    logic           ne;
    logic [2*W+1:0] sq;
  } vec_t;
  vec_t vecs[8];

  approx_err_monitor #(.W(W), .SAE_W(SAE_W), .SSE_W(SSE_W), .CNT_W(CNT_W)) u_dut (
    .Clk(Clk), .Rst(Rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .approx(approx), .exact(exact),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sae(sae), .sse(sse),
    .max_ae(max_ae), .ovf(ovf)
  );

  approx_err_monitor #(.W(W), .SAE_W(SAE8_W), .SSE_W(SSE_W), .CNT_W(CNT_W)) u_dut8 (
    .Clk(Clk), .Rst(Rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready8), .approx(approx), .exact(exact),
    .out_valid(out_valid8), .out_ready(out_ready), .busy(busy8),
    .sample_cnt(sample_cnt8), .err_cnt(err_cnt8), .sae(sae8), .sse(sse8),
    .max_ae(max_ae8), .ovf(ovf8)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=handshake within bound", name);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic start_run(input int n);
    @(negedge Clk);
    start = 1'b1;
    num_samples = n;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] e, input int gap);
    int guard;
    guard = 0;
    repeat (gap) @(negedge Clk);
    @(negedge Clk);
    in_valid = 1'b1; approx = a; exact = e;
    while (!in_ready && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 50) timeout_fail("in_ready_wait");
    @(posedge Clk);
    #1;
    in_valid = 1'b0; approx = $urandom; exact = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    @(negedge Clk);
    while (!out_valid && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 100) timeout_fail({tag, ".out_valid_wait"});
  endtask

  task automatic consume(input int delay);
    repeat (delay) @(negedge Clk);
    @(negedge Clk);
    out_ready = 1'b1;
    @(negedge Clk);
    out_ready = 1'b0;
  endtask

  // Statistics straight from the definitions: totals over the queued pairs,
  // then clamped to the accumulator range; ovf iff any total exceeded it.
  task automatic model_stats(input int sae_w, output logic [127:0] m_cnt, output logic [127:0] m_err,
                             output logic [127:0] m_sae, output logic [127:0] m_sse,
                             output logic [127:0] m_max, output logic m_ovf);
    logic [127:0] tot_sae, tot_sse, sae_lim, sse_lim;
    tot_sae = '0; tot_sse = '0; m_err = '0; m_max = '0;
    m_cnt = 128'(q_a.size());
    foreach (q_a[i]) begin
      longint d;
      logic [127:0] ae;
      d  = longint'(q_e[i]) - longint'(q_a[i]);
      ae = (d < 0) ? 128'(-d) : 128'(d);
      tot_sae += ae;
      tot_sse += ae * ae;
      if (ae > m_max) m_max = ae;
      if (q_a[i] != q_e[i]) m_err += 1;
    end
    sae_lim = (128'(1) << sae_w) - 1;
    sse_lim = (128'(1) << SSE_W) - 1;
    m_sae = (tot_sae > sae_lim) ? sae_lim : tot_sae;
    m_sse = (tot_sse > sse_lim) ? sse_lim : tot_sse;
    m_ovf = (tot_sae > sae_lim) || (tot_sse > sse_lim);
  endtask

  task automatic check_run(input string tag);
    logic [127:0] c, e, s, q, m, c8, e8, s8, q8, m8;
    logic o, o8;
    wait_done(tag);
    model_stats(SAE_W, c, e, s, q, m, o);
    model_stats(SAE8_W, c8, e8, s8, q8, m8, o8);
    chk({tag, ".sample_cnt"}, sample_cnt, c);
    chk({tag, ".err_cnt"}, err_cnt, e);
    chk({tag, ".sae"}, sae, s);
    chk({tag, ".sse"}, sse, q);
    chk({tag, ".max_ae"}, max_ae, m);
    chk({tag, ".ovf"}, ovf, o);
    chk({tag, ".sae8"}, sae8, s8);
    chk({tag, ".ovf8"}, ovf8, o8);
  endtask

  task automatic run_queue(input string tag, input int gap_max, input int out_delay);
    start_run(q_a.size());
    foreach (q_a[i]) send_pair(q_a[i], q_e[i], $urandom_range(0, gap_max));
    check_run(tag);
    consume(out_delay);
  endtask

  initial begin
    vecs[0] = '{a: 32'd10,         e: 32'd10,         ae: 33'd0,          ne: 1'b0, sq: 66'd0};
    vecs[1] = '{a: 32'd12,         e: 32'd10,         ae: 33'd2,          ne: 1'b1, sq: 66'd4};
    vecs[2] = '{a: 32'hFFFF_FFFB,  e: 32'd3,          ae: 33'd8,          ne: 1'b1, sq: 66'd64};
    vecs[3] = '{a: 32'd0,          e: 32'hFFFF_FFF9,  ae: 33'd7,          ne: 1'b1, sq: 66'd49};
    vecs[4] = '{a: 32'h7FFF_FFFF,  e: 32'h8000_0000,  ae: 33'h0_FFFF_FFFF, ne: 1'b1, sq: 66'h0_FFFF_FFFE_0000_0001};
    vecs[5] = '{a: 32'h8000_0000,  e: 32'h7FFF_FFFF,  ae: 33'h0_FFFF_FFFF, ne: 1'b1, sq: 66'h0_FFFF_FFFE_0000_0001};
    vecs[6] = '{a: 32'd3,          e: 32'd1,          ae: 33'd2,          ne: 1'b1, sq: 66'd4};
    vecs[7] = '{a: 32'd0,          e: 32'h8000_0000,  ae: 33'h0_8000_0000, ne: 1'b1, sq: 66'h0_4000_0000_0000_0000};

    // Reset state
    do_reset();
    chk("rst.busy", busy, 0);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.sample_cnt", sample_cnt, 0);
    chk("rst.err_cnt", err_cnt, 0);
    chk("rst.sae", sae, 0);
    chk("rst.sse", sse, 0);
    chk("rst.max_ae", max_ae, 0);
    chk("rst.ovf", ovf, 0);

    // Nominal run with exact handshake latency
    start_run(4);
    chk("nom.busy", busy, 1);
    chk("nom.in_ready", in_ready, 1);
    send_pair(32'd10, 32'd10, 0);
    send_pair(32'd12, 32'd10, 0);
    send_pair(32'hFFFF_FFFB, 32'd3, 0);
    send_pair(32'd0, 32'hFFFF_FFF9, 0);
    @(negedge Clk);
    chk("nom.in_ready_drop", in_ready, 0);
    chk("nom.out_valid_k0", out_valid, 0);
    @(negedge Clk);
    chk("nom.out_valid_k1", out_valid, 0);
    chk("nom.sample_cnt_k1", sample_cnt, 4);
    @(negedge Clk);
    chk("nom.out_valid_k2", out_valid, 1);
    chk("nom.sample_cnt", sample_cnt, 4);
    chk("nom.err_cnt", err_cnt, 3);
    chk("nom.sae", sae, 17);
    chk("nom.sse", sse, 117);
    chk("nom.max_ae", max_ae, 8);
    chk("nom.ovf", ovf, 0);

    // Back-pressure: record held, start ignored
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      num_samples = 3;
      @(negedge Clk);
      chk("bp.out_valid", out_valid, 1);
      chk("bp.sae", sae, 17);
      chk("bp.sample_cnt", sample_cnt, 4);
    end
    start = 1'b0;
    consume(0);
    chk("bp.idle_out_valid", out_valid, 0);
    chk("bp.idle_busy", busy, 0);
    chk("bp.idle_sae_kept", sae, 17);

    // Empty run
    start_run(0);
    chk("empty.out_valid", out_valid, 1);
    chk("empty.in_ready", in_ready, 0);
    chk("empty.sample_cnt", sample_cnt, 0);
    chk("empty.err_cnt", err_cnt, 0);
    chk("empty.sae", sae, 0);
    chk("empty.sse", sse, 0);
    chk("empty.max_ae", max_ae, 0);
    consume(1);
    chk("empty.idle_busy", busy, 0);

    // Single-pair table
    for (int i = 0; i < 8; i++) begin
      start_run(1);
      send_pair(vecs[i].a, vecs[i].e, 0);
      wait_done($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.sample_cnt", i), sample_cnt, 1);
      chk($sformatf("tbl%0d.err_cnt", i), err_cnt, vecs[i].ne);
      chk($sformatf("tbl%0d.sae", i), sae, vecs[i].ae);
      chk($sformatf("tbl%0d.sse", i), sse, vecs[i].sq);
      chk($sformatf("tbl%0d.max_ae", i), max_ae, vecs[i].ae);
      chk($sformatf("tbl%0d.ovf", i), ovf, 0);
      chk($sformatf("tbl%0d.sae8", i), sae8, (vecs[i].ae > 255) ? 255 : vecs[i].ae);
      chk($sformatf("tbl%0d.ovf8", i), ovf8, (vecs[i].ae > 255) ? 1 : 0);
      consume(i % 3);
    end

    // Reset in the middle of a run
    start_run(4);
    send_pair(32'd1, 32'd5, 0);
    send_pair(32'd2, 32'd9, 0);
    @(negedge Clk);
    chk("mid.pre_sample_cnt", sample_cnt, 1);
    Rst = 1'b1;
    #1;
    chk("mid.busy", busy, 0);
    chk("mid.in_ready", in_ready, 0);
    chk("mid.sample_cnt", sample_cnt, 0);
    chk("mid.err_cnt", err_cnt, 0);
    chk("mid.sae", sae, 0);
    chk("mid.sse", sse, 0);
    chk("mid.max_ae", max_ae, 0);
    @(negedge Clk);
    Rst = 1'b0;
    q_a = {}; q_e = {};
    q_a.push_back(32'd3); q_e.push_back(32'd1);
    run_queue("post_rst", 0, 0);
    chk("post_rst.sae_const", sae, 2);

    // Saturation of the narrow SAE accumulator
    q_a = {}; q_e = {};
    q_a.push_back(32'd0);   q_e.push_back(32'd200);
    q_a.push_back(32'd100); q_e.push_back(32'hFFFF_FF9C);
    start_run(2);
    foreach (q_a[i]) send_pair(q_a[i], q_e[i], 1);
    check_run("sat");
    chk("sat.sae8_const", sae8, 255);
    chk("sat.ovf8_const", ovf8, 1);
    chk("sat.sae_wide", sae, 400);
    repeat (3) @(negedge Clk);
    chk("sat.ovf8_hold", ovf8, 1);
    consume(0);
    chk("sat.ovf8_idle", ovf8, 1);
    start_run(1);
    chk("sat.ovf8_cleared", ovf8, 0);
    chk("sat.sae8_cleared", sae8, 0);
    q_a = {}; q_e = {};
    q_a.push_back(32'd0); q_e.push_back(32'd0);
    send_pair(32'd0, 32'd0, 0);
    check_run("sat_next");
    consume(0);

    // Randomised runs against the model
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, 16);
      q_a = {}; q_e = {};
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          q_a.push_back($urandom);
          q_e.push_back($urandom);
        end else begin
          q_a.push_back(32'($urandom_range(0, 400)) - 32'd200);
          q_e.push_back(($urandom_range(0, 3) == 0) ? q_a[k] : 32'($urandom_range(0, 400)) - 32'd200);
        end
      end
      run_queue($sformatf("rnd%0d", r), 2, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
Name: approx_err_monitor

Overview:
- On-chip consumer for approximate-adder characterisation; the hardware counterpart of the file-driven bench flow.
- Accepts a stream of (approximate, exact) signed result pairs over a valid/ready handshake.
- Accumulates count, erroneous-result count, sum of absolute error (SAE), sum of squared error (SSE) and max absolute error for a programmed number of samples.
- Presents one statistics record over a second valid/ready handshake.

Parameters:
- W, 32: operand/result width (two's complement).
- SAE_W, 64: SAE accumulator width.
- SSE_W, 96: SSE accumulator width.
- CNT_W, 32: sample and error counter width.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when IDLE.
- num_samples  in  CNT_W  samples per run; sampled on an accepted start.
- in_valid  in  1  pair valid.
- in_ready  out  1  pair accepted when in_valid && in_ready.
- approx  in  W  signed approximate result.
- exact  in  W  signed exact result.
- out_valid  out  1  statistics record valid.
- out_ready  in  1  record consumed when out_valid && out_ready.
- busy  out  1  high in any state except IDLE.
- sample_cnt  out  CNT_W  pairs accepted.
- err_cnt  out  CNT_W  pairs with approx != exact.
- sae  out  SAE_W  sum of |exact-approx|.
- sse  out  SSE_W  sum of (exact-approx)^2.
- max_ae  out  W+1  maximum |exact-approx|.
- ovf  out  1  sticky; any accumulator or counter saturated.

Behaviour:
- Reset (async, any state): FSM=IDLE; all outputs 0; pipeline valid bits cleared; in_ready=0. Any in-flight run is discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1: clear all accumulators, counters and ovf; latch num_samples into target.
  - target=0 -> DONE on that edge. Otherwise -> RUN.
  - start is ignored in every state other than IDLE.
- RUN:
  - in_ready = 1 while accepted < target.
  - On the accept that makes accepted == target -> DRAIN; in_ready drops on that same edge.
- Pipeline, 2 stages:
  - Stage 1, registered on the accept edge k: ae = |sign-extended exact - sign-extended approx| at W+1 bits; ne = (approx != exact).
  - Stage 2, at edge k+1: ae^2 (2W+2 bits) added to sse; ae added to sae; max_ae = max(max_ae, ae); err_cnt += ne; sample_cnt += 1.
- DRAIN -> DONE when both pipeline stages are empty. out_valid is high from edge k+2 after the last accept.
- Saturation:
  - Each accumulator/counter clamps at all-ones instead of wrapping.
  - ovf is set on the edge any clamp occurs and stays set until the next accepted start.
- DONE:
  - out_valid=1; all statistic outputs are stable while out_valid && !out_ready.
  - On out_ready -> IDLE with out_valid=0.
  - Statistics remain readable in IDLE until the next accepted start clears them.
- Output timing:
  - Statistic outputs track the accumulators live during RUN/DRAIN.
  - Consumers sample them only when out_valid=1.
- in_valid with in_ready=0 has no effect. approx/exact are don't-care when not accepted.
- W+1-bit ae covers the full range: exact=-2^(W-1), approx=2^(W-1)-1 gives ae=2^W-1.

Decomposition:
- Shared package approx_stats_pkg:
  - FSM state enum {IDLE, RUN, DRAIN, DONE}.
  - Default width constants W, SAE_W, SSE_W, CNT_W.
  - Saturating-add function.
- Sub-module err_sq_stage: the two-stage |diff| and square pipeline, with valid passthrough.
- FSM, counters and accumulators stay in the top module.

Test Plan:
- Nominal run: Rst; start with num_samples=4; pairs (10,10), (12,10), (-5,3), (0,-7) -> out_valid; sample_cnt=4, err_cnt=3, sae=17, sse=117, max_ae=8, ovf=0.
- Empty run: num_samples=0 -> out_valid after the start edge; all stats 0; in_ready never asserted.
- Extreme pair: approx=0x7FFFFFFF, exact=0x80000000, n=1 -> max_ae=0xFFFFFFFF, sae=0xFFFFFFFF, sse=0xFFFFFFFE00000001.
- Back-pressure: out_ready held low 5 cycles while start pulses -> stats and out_valid unchanged, start ignored; out_ready=1 -> IDLE. A new start clears stats.
- Reset mid-run: assert Rst after 2 of 4 accepts -> immediately busy=0, in_ready=0, all stats 0; a following run of 1 pair (3,1) gives sae=2.
- Saturation with SAE_W=8: two pairs with ae=200 -> sae=255, ovf=1; ovf persists through DONE and clears on the next start.
